// File: rtl/rce_parity_accumulator.sv
// Parity-accumulation stage of the rotating-circulant encoder: XORs rotated generator words into a parity register.
// Optional `RCE_SKIP_ZERO_EN retires all-zero LM-bit message chunks in one cycle.
module rce_parity_accumulator #(
  parameter int K_N = 256,
  parameter int LM  = 16   // must be a power of two
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LM-1:0]    msg,
  output logic [1:0]         adrs,
  input  logic [K_N-1:0]     f,
  output logic [K_N-1:0]     parity,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int NB = 4 * LM;
  localparam int CW = $clog2(NB);
  localparam int JW = $clog2(LM);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NB-1:0]   msg_reg;

  logic [JW-1:0]   j;
  logic [K_N-1:0]  f_rot;
  logic            cur_bit;
  logic            last_step;
  logic [CW-1:0]   cnt_next;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    j         = cnt[JW-1:0];
    f_rot     = (f << j) | (f >> (K_N - int'(j)));
    cur_bit   = msg_reg[cnt];
    last_step = (cnt == CW'(NB - 1));
    cnt_next  = cnt + CW'(1);
`ifdef RCE_SKIP_ZERO_EN
    // At a chunk boundary an all-zero chunk contributes nothing, so jump to the next chunk.
    if ((j == '0) && (msg_reg[int'(cnt[CW-1 -: 2]) * LM +: LM] == '0)) begin
      last_step = (cnt[CW-1 -: 2] == 2'd3);
      cnt_next  = cnt + CW'(LM);
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: msg_reg is reset along with the rest so an aborted block leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      msg_reg   <= '0;
      parity    <= '0;
      adrs      <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            msg_reg  <= msg;
            parity   <= '0;
            cnt      <= '0;
            adrs     <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end

        ACC: begin
          if (cur_bit) begin
            parity <= parity ^ f_rot;
          end
          // adrs and cnt freeze on the final step so DONE holds the last address.
          if (last_step) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt  <= cnt_next;
            adrs <= cnt_next[CW-1 -: 2];
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            adrs      <= 2'd0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rce_parity_accumulator.sv
// Directed bench for rce_parity_accumulator with a 4-word combinational generator model.
// Expected latencies follow `RCE_SKIP_ZERO_EN when it is defined.
module tb_rce_parity_accumulator;

  localparam logic [255:0] GEN0 = 256'h32C682B95BE87202_4F8682DC7499AC4A_D1D2D257873D0962_856C5B9F8DD9C268;
  localparam logic [255:0] GEN1 = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_1357924680ACE0F1;
  localparam logic [255:0] GEN2 = 256'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  localparam logic [255:0] GEN3 = 256'h8000000000000001_7FFFFFFFFFFFFFFE_C3C3C3C3C3C3C3C3_0000FFFF0000FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  msg;
  logic [1:0]   adrs;
  logic [255:0] f;
  logic [255:0] parity;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  rce_parity_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg       (msg),
    .adrs      (adrs),
    .f         (f),
    .parity    (parity),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    f = GEN0;
    case (adrs)
      2'd1:    f = GEN1;
      2'd2:    f = GEN2;
      2'd3:    f = GEN3;
      default: f = GEN0;
    endcase
  end

  function automatic logic [255:0] gen_word(input int a);
    case (a)
      1:       return GEN1;
      2:       return GEN2;
      3:       return GEN3;
      default: return GEN0;
    endcase
  endfunction

  function automatic logic [255:0] rotl(input logic [255:0] w, input int s);
    logic [255:0] r;
    for (int i = 0; i < 256; i++) r[(i + s) % 256] = w[i];
    return r;
  endfunction

  function automatic logic [255:0] model_parity(input logic [63:0] m);
    logic [255:0] p = '0;
    for (int i = 0; i < 64; i++)
      if (m[i]) p = p ^ rotl(gen_word(i / 16), i % 16);
    return p;
  endfunction

  function automatic int model_latency(input logic [63:0] m);
    int lat = 0;
    for (int c = 0; c < 4; c++) begin
`ifdef RCE_SKIP_ZERO_EN
      lat += (((m >> (16 * c)) & 64'hFFFF) == 64'h0) ? 1 : 16;
`else
      lat += 16;
`endif
    end
    return lat;
  endfunction

  // Called at posedge+1 in IDLE; returns edges from accept until out_valid is seen.
  task automatic run_block(input logic [63:0] m, output int cyc, output bit to);
    msg      = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = !out_valid;
  endtask

  task automatic release_block();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; msg = '0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, busy, adrs} !== 5'b1_0_0_00) begin
      n_err++;
      $display("FAIL reset_ctrl got %b exp 10000", {in_ready, out_valid, busy, adrs});
    end
    n_cmp++;
    if (parity !== '0) begin n_err++; $display("FAIL reset_parity got %h exp 0", parity); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [63:0] m, input logic [255:0] exp_p);
    int cyc; bit to;
    run_block(m, cyc, to);
    n_cmp++;
    if (to || cyc != model_latency(m)) begin
      n_err++; $display("FAIL %s_latency got %0d (timeout=%0d) exp %0d", name, cyc, to, model_latency(m));
    end
    n_cmp++;
    if (parity !== exp_p) begin n_err++; $display("FAIL %s_parity got %h exp %h", name, parity, exp_p); end
    n_cmp++;
    if ({in_ready, busy, adrs} !== 4'b0_1_11) begin
      n_err++; $display("FAIL %s_done_ctrl got %b exp 0111", name, {in_ready, busy, adrs});
    end
    release_block();
    n_cmp++;
    if ({in_ready, out_valid, busy, adrs} !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL %s_idle_ctrl got %b exp 10000", name, {in_ready, out_valid, busy, adrs});
    end
  endtask

  task automatic test_all_ones();
    int bad = 0;
    msg = '1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (adrs !== 2'(k / 16)) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL ones_adrs_seq got %0d bad cycles exp 0", bad); end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL ones_out_valid got %b exp 1", out_valid); end
    n_cmp++;
    if (parity !== model_parity('1)) begin
      n_err++; $display("FAIL ones_parity got %h exp %h", parity, model_parity('1));
    end
    release_block();
  endtask

  task automatic test_hold_done();
    int cyc; bit to; int bad = 0;
    logic [255:0] exp_p = {GEN0[254:0], GEN0[255]};
    run_block(64'h2, cyc, to);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin msg = 64'hFFFF; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (parity !== exp_p || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (to || bad != 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles (timeout=%0d) exp 0", bad, to); end
    release_block();
    test_vector("after_hold", 64'h1, GEN0);
  endtask

  task automatic test_reset_mid();
    msg = '1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, adrs} !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL midrst_ctrl got %b exp 10000", {in_ready, out_valid, busy, adrs});
    end
    n_cmp++;
    if (parity !== '0) begin n_err++; $display("FAIL midrst_parity got %h exp 0", parity); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    test_vector("post_rst", 64'h1, GEN0);
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [255:0] exp_p = GEN0 ^ {GEN0[254:0], GEN0[255]};
    msg = 64'h3; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (!out_valid || parity !== exp_p) begin
      n_err++; $display("FAIL b2b_first got %h exp %h", parity, exp_p);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_idle_gap got %b exp 10", {in_ready, out_valid});
    end
    cyc = 1;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b0;
    to = !out_valid;
    n_cmp++;
    if (to || cyc != 2 + model_latency(64'h3)) begin
      n_err++; $display("FAIL b2b_period got %0d exp %0d", cyc, 2 + model_latency(64'h3));
    end
    n_cmp++;
    if (parity !== exp_p) begin n_err++; $display("FAIL b2b_second got %h exp %h", parity, exp_p); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL b2b_end got %b exp 10", {in_ready, busy});
    end
  endtask

  initial begin
    test_reset();
    test_vector("word0", 64'h1, GEN0);
    test_vector("rot1", 64'h2, {GEN0[254:0], GEN0[255]});
    test_vector("w1w3", 64'h0001_0000_0001_0000, GEN1 ^ GEN3);
    test_vector("zero", 64'h0, 256'h0);
    test_all_ones();
    test_hold_done();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
